// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port main-memory arbiter: FSM encoding,
// port identifiers and default geometry.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam int DEF_AW      = 8;
    localparam int DEF_DW      = 8;
    localparam int DEF_TIMEOUT = 16;
    localparam int DEF_TW      = 8;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: a lone requester wins outright, a tie goes
// to the port that was not served last.
module rr_pick2
    import mem_arb_pkg::*;
(
    input  logic req1_i,
    input  logic req2_i,
    input  logic last_i,
    output logic valid_o,
    output logic winner_o
);

    always_comb begin
        valid_o  = req1_i | req2_i;
        winner_o = P1;
        if (req1_i && req2_i) begin
            winner_o = (last_i == P1) ? P2 : P1;
        end else if (req2_i) begin
            winner_o = P2;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between two cache controllers: round-robin
// grant, single-strobe memory handshake with timeout, write invalidates.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TW      = DEF_TW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    input  logic          req2,
    input  logic          we2,
    input  logic [AW-1:0] addr2,
    input  logic [DW-1:0] wdata2,
    output logic          gnt1,
    output logic          gnt2,
    output logic          done1,
    output logic          done2,
    output logic          err,
    output logic [DW-1:0] rdata,
    output logic          inv1,
    output logic          inv2,
    output logic [AW-1:0] inv_addr,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    state_t        state_q, state_d;
    logic          win_q, win_d;
    logic          last_q, last_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [AW-1:0] inv_addr_q, inv_addr_d;
    logic          gnt1_q, gnt1_d, gnt2_q, gnt2_d;
    logic          done1_q, done1_d, done2_q, done2_d;
    logic          err_q, err_d;
    logic          inv1_q, inv1_d, inv2_q, inv2_d;
    logic          mem_en_q, mem_en_d;

    logic pick_valid;
    logic pick_winner;

    rr_pick2 u_pick (
        .req1_i  (req1),
        .req2_i  (req2),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .winner_o(pick_winner)
    );

    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        last_d     = last_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        inv_addr_d = inv_addr_q;
        err_d      = 1'b0;
        inv1_d     = 1'b0;
        inv2_d     = 1'b0;
        mem_en_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d    = pick_winner;
                    state_d  = ACCESS;
                    mem_en_d = 1'b1;
                    if (pick_winner == P2) begin
                        we_d    = we2;
                        addr_d  = addr2;
                        wdata_d = wdata2;
                    end else begin
                        we_d    = we1;
                        addr_d  = addr1;
                        wdata_d = wdata1;
                    end
                end
            end
            ACCESS: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (mem_ready) begin
                    state_d = DONE;
                    if (we_q) begin
                        // A completed write makes the other cache's copy stale.
                        inv1_d     = (win_q == P2);
                        inv2_d     = (win_q == P1);
                        inv_addr_d = addr_q;
                    end else begin
                        rdata_d = mem_rdata;
                    end
                end else if (cnt_q == TW'(TIMEOUT - 1)) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                last_d  = win_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Grant and done are derived from the next state so they line up with it.
        gnt1_d  = (state_d != IDLE) && (win_d == P1);
        gnt2_d  = (state_d != IDLE) && (win_d == P2);
        done1_d = (state_d == DONE) && (win_d == P1);
        done2_d = (state_d == DONE) && (win_d == P2);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            win_q      <= P1;
            last_q     <= P2;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            inv_addr_q <= '0;
            gnt1_q     <= 1'b0;
            gnt2_q     <= 1'b0;
            done1_q    <= 1'b0;
            done2_q    <= 1'b0;
            err_q      <= 1'b0;
            inv1_q     <= 1'b0;
            inv2_q     <= 1'b0;
            mem_en_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            last_q     <= last_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            inv_addr_q <= inv_addr_d;
            gnt1_q     <= gnt1_d;
            gnt2_q     <= gnt2_d;
            done1_q    <= done1_d;
            done2_q    <= done2_d;
            err_q      <= err_d;
            inv1_q     <= inv1_d;
            inv2_q     <= inv2_d;
            mem_en_q   <= mem_en_d;
        end
    end

    assign gnt1      = gnt1_q;
    assign gnt2      = gnt2_q;
    assign done1     = done1_q;
    assign done2     = done2_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign inv1      = inv1_q;
    assign inv2      = inv2_q;
    assign inv_addr  = inv_addr_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: transaction-timeline model checked every cycle,
// plus directed latency/ordering/data expectations.
module tb_mem_port_arbiter;

    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req1 = 1'b0, we1 = 1'b0, req2 = 1'b0, we2 = 1'b0;
    logic [7:0] addr1 = '0, wdata1 = '0, addr2 = '0, wdata2 = '0;
    logic       gnt1, gnt2, done1, done2, err, inv1, inv2;
    logic [7:0] rdata, inv_addr, mem_addr, mem_wdata;
    logic       mem_en, mem_we;
    logic [7:0] mem_rdata = '0;
    logic       mem_ready = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(8), .DW(8), .TIMEOUT(TIMEOUT), .TW(8)) dut (
        .clk(clk), .rst(rst),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .req2(req2), .we2(we2), .addr2(addr2), .wdata2(wdata2),
        .gnt1(gnt1), .gnt2(gnt2), .done1(done1), .done2(done2), .err(err),
        .rdata(rdata), .inv1(inv1), .inv2(inv2), .inv_addr(inv_addr),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 0;
    int edge_cnt = 0;

    // Model: a transaction is owned by a port from its grant edge; age counts
    // edges since the grant; the first cycle is the strobe, then waiting.
    int         m_owner = 0;
    int         m_last = 2;
    int         m_age = 0;
    bit         m_fin = 0;
    logic       m_we;
    logic [7:0] m_addr, m_wdata;
    logic       e_gnt1, e_gnt2, e_done1, e_done2, e_err, e_inv1, e_inv2, e_mem_en;
    logic       e_mem_we, e_after_rst;
    logic [7:0] e_rdata, e_inv_addr, e_mem_addr, e_mem_wdata;

    always @(posedge clk) begin
        edge_cnt++;
        e_mem_en = 0; e_done1 = 0; e_done2 = 0; e_err = 0; e_inv1 = 0; e_inv2 = 0;
        e_after_rst = rst;
        if (rst) begin
            m_owner = 0; m_last = 2; m_fin = 0; m_age = 0;
            e_gnt1 = 0; e_gnt2 = 0; e_rdata = 0; e_inv_addr = 0;
            e_mem_we = 0; e_mem_addr = 0; e_mem_wdata = 0;
        end else if (m_owner == 0) begin
            if (req1 || req2) begin
                if (req1 && req2) m_owner = (m_last == 1) ? 2 : 1;
                else              m_owner = req1 ? 1 : 2;
                m_we    = (m_owner == 1) ? we1 : we2;
                m_addr  = (m_owner == 1) ? addr1 : addr2;
                m_wdata = (m_owner == 1) ? wdata1 : wdata2;
                m_age = 0;
                e_mem_en = 1; e_mem_we = m_we; e_mem_addr = m_addr; e_mem_wdata = m_wdata;
                e_gnt1 = (m_owner == 1); e_gnt2 = (m_owner == 2);
            end
        end else if (m_fin) begin
            m_last = m_owner; m_owner = 0; m_fin = 0;
            e_gnt1 = 0; e_gnt2 = 0;
        end else if (m_age == 0) begin
            m_age = 1;
        end else if (mem_ready) begin
            m_fin = 1;
            e_done1 = (m_owner == 1); e_done2 = (m_owner == 2);
            if (!m_we) e_rdata = mem_rdata;
            else begin
                e_inv1 = (m_owner == 2); e_inv2 = (m_owner == 1); e_inv_addr = m_addr;
            end
        end else if (m_age == TIMEOUT) begin
            m_fin = 1;
            e_done1 = (m_owner == 1); e_done2 = (m_owner == 2); e_err = 1;
        end else begin
            m_age++;
        end
    end

    // Event tallies gathered by the compare thread
    int         n_mem_en = 0, n_done = 0, n_err = 0, n_inv = 0, n_gnt2 = 0;
    int         order[$];
    logic       last_mwe;
    logic [7:0] last_maddr, last_mwdata;

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (chk_on) begin
                checks++;
                if ({gnt1, gnt2, done1, done2, err, inv1, inv2, mem_en} !==
                        {e_gnt1, e_gnt2, e_done1, e_done2, e_err, e_inv1, e_inv2, e_mem_en}
                    || rdata !== e_rdata
                    || ((e_mem_en || e_after_rst) &&
                        {mem_we, mem_addr, mem_wdata} !== {e_mem_we, e_mem_addr, e_mem_wdata})
                    || ((e_inv1 || e_inv2 || e_after_rst) && inv_addr !== e_inv_addr)) begin
                    errors++;
                    $display("FAIL cycle_cmp edge %0d: got g%b%b d%b%b e%b i%b%b en%b we%b a%h wd%h rd%h ia%h, expected g%b%b d%b%b e%b i%b%b en%b we%b a%h wd%h rd%h ia%h",
                             edge_cnt, gnt1, gnt2, done1, done2, err, inv1, inv2, mem_en, mem_we,
                             mem_addr, mem_wdata, rdata, inv_addr, e_gnt1, e_gnt2, e_done1, e_done2,
                             e_err, e_inv1, e_inv2, e_mem_en, e_mem_we, e_mem_addr, e_mem_wdata,
                             e_rdata, e_inv_addr);
                end
                if (mem_en === 1'b1) begin
                    n_mem_en++; last_mwe = mem_we; last_maddr = mem_addr; last_mwdata = mem_wdata;
                end
                if (done1 === 1'b1) begin n_done++; order.push_back(1); end
                if (done2 === 1'b1) begin n_done++; order.push_back(2); end
                if (err === 1'b1) n_err++;
                if (inv1 === 1'b1 || inv2 === 1'b1) n_inv++;
                if (gnt2 === 1'b1) n_gnt2++;
            end
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int port, input int k, input int bound, output int lat);
        lat = -1;
        for (int i = 0; i < bound; i++) begin
            step();
            if ((port == 1 && done1 === 1'b1) || (port == 2 && done2 === 1'b1)) begin
                lat = edge_cnt - k;
                break;
            end
        end
        if (lat < 0) begin
            checks++; errors++;
            $display("FAIL wait_done%0d: got no done within %0d cycles, expected a done pulse", port, bound);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        chk_on = 1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int k, lat, en0, inv0, err0, done0, g0;
        fork
            compare_loop();
        join_none

        // Reset state
        do_reset();
        chk("reset_rdata", int'(rdata), 0);
        chk("reset_gnt", int'({gnt1, gnt2, done1, done2, mem_en}), 0);

        // Single read
        mem_ready = 1; mem_rdata = 8'h5A;
        en0 = n_mem_en; g0 = n_gnt2; inv0 = n_inv;
        k = edge_cnt; req1 = 1; we1 = 0; addr1 = 8'h01;
        wait_done(1, k, 10, lat);
        req1 = 0;
        chk("read_latency", lat, 3);
        chk("read_rdata", int'(rdata), 8'h5A);
        step(); step();
        chk("read_mem_en_count", n_mem_en - en0, 1);
        chk("read_mem_addr", int'(last_maddr), 1);
        chk("read_mem_we", int'(last_mwe), 0);
        chk("read_no_inv", n_inv - inv0, 0);
        chk("read_no_gnt2", n_gnt2 - g0, 0);

        // Tie after reset, both held: 1,2,1,2
        do_reset();
        order.delete();
        k = edge_cnt; req1 = 1; req2 = 1; we1 = 0; we2 = 0; addr2 = 8'h02;
        wait_done(1, k, 10, lat);
        chk("tie_done1_latency", lat, 3);
        wait_done(2, k, 10, lat);
        chk("tie_done2_latency", lat, 7);
        for (int i = 0; i < 20 && order.size() < 4; i++) step();
        req1 = 0; req2 = 0;
        chk("tie_count", order.size(), 4);
        if (order.size() >= 4) begin
            chk("tie_order0", order[0], 1);
            chk("tie_order1", order[1], 2);
            chk("tie_order2", order[2], 1);
            chk("tie_order3", order[3], 2);
        end
        step(); step(); step();

        // Write from port 2 invalidates port 1
        inv0 = n_inv;
        k = edge_cnt; req2 = 1; we2 = 1; addr2 = 8'h01; wdata2 = 8'd99;
        wait_done(2, k, 10, lat);
        chk("write_latency", lat, 3);
        chk("write_inv1", int'(inv1), 1);
        chk("write_inv2", int'(inv2), 0);
        chk("write_inv_addr", int'(inv_addr), 1);
        chk("write_rdata_kept", int'(rdata), 8'h5A);
        req2 = 0; we2 = 0;
        step(); step();
        chk("write_mem_we", int'(last_mwe), 1);
        chk("write_mem_wdata", int'(last_mwdata), 99);
        chk("write_inv_count", n_inv - inv0, 1);

        // Timeout, then a normal request
        mem_ready = 0;
        en0 = n_mem_en; inv0 = n_inv;
        k = edge_cnt; req1 = 1; we1 = 0; addr1 = 8'h02;
        wait_done(1, k, 40, lat);
        chk("timeout_latency", lat, TIMEOUT + 2);
        chk("timeout_err", int'(err), 1);
        req1 = 0;
        step(); step(); step();
        chk("timeout_mem_en_count", n_mem_en - en0, 1);
        chk("timeout_no_inv", n_inv - inv0, 0);
        mem_ready = 1; mem_rdata = 8'hC3;
        k = edge_cnt; req1 = 1;
        wait_done(1, k, 10, lat);
        chk("after_timeout_latency", lat, 3);
        chk("after_timeout_err", int'(err), 0);
        chk("after_timeout_rdata", int'(rdata), 8'hC3);
        req1 = 0;
        step(); step();

        // Late ready on the 5th wait cycle, request dropped mid-wait
        mem_ready = 0; mem_rdata = 8'h7E;
        en0 = n_mem_en;
        k = edge_cnt; req1 = 1; lat = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (edge_cnt == k + 3) req1 = 0;
            if (edge_cnt == k + 6) mem_ready = 1;
            if (done1 === 1'b1) begin lat = edge_cnt - k; break; end
        end
        chk("late_ready_latency", lat, 7);
        chk("late_ready_rdata", int'(rdata), 8'h7E);
        step(); step(); step(); step();
        chk("late_ready_mem_en_count", n_mem_en - en0, 1);

        // Reset in the middle of WAIT
        mem_ready = 0;
        k = edge_cnt; req1 = 1; addr1 = 8'h33;
        step(); step(); step(); step();
        done0 = n_done; err0 = n_err; inv0 = n_inv;
        rst = 1;
        step();
        chk("midrst_outputs", int'({gnt1, gnt2, done1, done2, err, inv1, inv2, mem_en}), 0);
        chk("midrst_rdata", int'(rdata), 0);
        chk("midrst_mem_addr", int'(mem_addr), 0);
        rst = 0; req1 = 0; mem_ready = 1; mem_rdata = 8'h11;
        step(); step(); step(); step(); step();
        chk("midrst_no_done", n_done - done0, 0);
        chk("midrst_no_err", n_err - err0, 0);
        chk("midrst_no_inv", n_inv - inv0, 0);
        order.delete();
        req1 = 1; req2 = 1; we2 = 0;
        for (int i = 0; i < 12 && order.size() < 1; i++) step();
        req1 = 0; req2 = 0;
        chk("midrst_tie_count", order.size(), 1);
        if (order.size() >= 1) chk("midrst_tie_winner", order[0], 1);
        for (int i = 0; i < 8; i++) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
